// File: rtl/complex_multiply_pipe.sv
// complex_multiply_pipe: three-stage streaming complex multiplier, A*B or A*conj(B),
// with round-half-up, arithmetic shift and saturation to OUT_WIDTH.
// A single global stall freezes every stage while the output is valid but not accepted.
// Optional macro COMPLEX_MULTIPLY_PIPE_SAT_FLAG_EN adds sat_out, a per-sample clamp flag.
module complex_multiply_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 15
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic signed [DATA_WIDTH-1:0] i0_in,
  input  logic signed [DATA_WIDTH-1:0] q0_in,
  input  logic signed [DATA_WIDTH-1:0] i1_in,
  input  logic signed [DATA_WIDTH-1:0] q1_in,
  input  logic                         conj_in,
  input  logic                         last_in,
  input  logic                         valid_in,
  output logic                         ready_out,
  output logic signed [OUT_WIDTH-1:0]  i_out,
  output logic signed [OUT_WIDTH-1:0]  q_out,
  output logic                         last_out,
  output logic                         valid_out,
`ifdef COMPLEX_MULTIPLY_PIPE_SAT_FLAG_EN
  output logic                         sat_out,
`endif
  input  logic                         ready_in
);

  localparam int STAGES = 3;
  localparam int PW     = 2*DATA_WIDTH;      // product of two DATA_WIDTH operands
  localparam int BW     = DATA_WIDTH + 1;    // negated Q of B: -min must be representable
  localparam int W      = 2*DATA_WIDTH + 2;  // sum/difference of products, cannot overflow
  localparam int WR     = W + 1;             // headroom for the rounding constant

  localparam logic signed [WR-1:0] RND     = (WR'(1) << SHIFT) >> 1;
  localparam logic signed [WR-1:0] SAT_MAX = (WR'(1) << (OUT_WIDTH-1)) - WR'(1);
  localparam logic signed [WR-1:0] SAT_MIN = -(WR'(1) << (OUT_WIDTH-1));

  logic [STAGES:1] vld_pipe;
  logic            stall;

  logic signed [DATA_WIDTH-1:0] s1_ai, s1_aq, s1_bi;
  logic signed [BW-1:0]         s1_bq;
  logic                         s1_last;

  logic signed [PW-1:0] s2_ii, s2_qi;
  logic signed [PW:0]   s2_qq, s2_iq;
  logic                 s2_last;

  logic signed [WR-1:0]        re_full, im_full, re_rnd, im_rnd;
  logic signed [OUT_WIDTH-1:0] re_sat, im_sat;

  assign stall     = valid_out && !ready_in;
  assign ready_out = !stall;
  assign valid_out = vld_pipe[STAGES];

  function automatic logic signed [WR-1:0] clamp(input logic signed [WR-1:0] v);
    if (v > SAT_MAX) return SAT_MAX;
    if (v < SAT_MIN) return SAT_MIN;
    return v;
  endfunction

  // Valid shift register; bubbles travel with the data and are not squeezed out.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)   vld_pipe <= '0;
    else if (!stall) vld_pipe <= {vld_pipe[STAGES-1:1], valid_in};
  end

  // Datapath stages 1 and 2: capture operands (conjugating B), then form the four products.
  always_ff @(posedge clk_in) begin
    if (!stall) begin
      s1_ai   <= i0_in;
      s1_aq   <= q0_in;
      s1_bi   <= i1_in;
      s1_bq   <= conj_in ? -BW'(q1_in) : BW'(q1_in);
      s1_last <= last_in;
      s2_ii   <= PW'(s1_ai) * PW'(s1_bi);
      s2_qi   <= PW'(s1_aq) * PW'(s1_bi);
      s2_qq   <= (PW+1)'(s1_aq) * (PW+1)'(s1_bq);
      s2_iq   <= (PW+1)'(s1_ai) * (PW+1)'(s1_bq);
      s2_last <= s1_last;
    end
  end

  // Stage 3 combine: full-precision sum, round half up, shift, clamp.
  always_comb begin
    re_full = WR'(s2_ii) - WR'(s2_qq);
    im_full = WR'(s2_iq) + WR'(s2_qi);
    re_rnd  = (re_full + RND) >>> SHIFT;
    im_rnd  = (im_full + RND) >>> SHIFT;
    re_sat  = OUT_WIDTH'(clamp(re_rnd));
    im_sat  = OUT_WIDTH'(clamp(im_rnd));
  end

  // Output register, cleared by reset and frozen while stalled.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      i_out    <= '0;
      q_out    <= '0;
      last_out <= 1'b0;
    end else if (!stall) begin
      i_out    <= re_sat;
      q_out    <= im_sat;
      last_out <= s2_last;
    end
  end

`ifdef COMPLEX_MULTIPLY_PIPE_SAT_FLAG_EN
  logic clip;
  assign clip = (re_rnd > SAT_MAX) || (re_rnd < SAT_MIN) ||
                (im_rnd > SAT_MAX) || (im_rnd < SAT_MIN);

  // Clamp flag registered alongside the data it describes.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)   sat_out <= 1'b0;
    else if (!stall) sat_out <= clip;
  end
`endif

endmodule

// File: doc/complex_multiply_pipe.md
Name: complex_multiply_pipe

Overview:
Parametrised, pipelined complex multiplier with valid/ready streaming handshake, per-sample conjugate select, and round-and-saturate output scaling to a configurable width. It is the streaming successor to the single-register complex multiplier. It sits in the CSI extraction datapath for channel estimation (received symbol × conj(reference pilot)) and for frequency-offset derotation. A last flag travels alongside the data so that symbol boundaries survive the pipeline.

Parameters:
DATA_WIDTH, 16, signed input component width (I and Q of each operand)
OUT_WIDTH, 16, signed output component width after scaling; 2 ≤ OUT_WIDTH ≤ 2*DATA_WIDTH+2
SHIFT, 15, arithmetic right shift applied to full-precision result; 0 ≤ SHIFT ≤ 2*DATA_WIDTH

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
i0_in, q0_in  input  DATA_WIDTH  operand A (signed)
i1_in, q1_in  input  DATA_WIDTH  operand B (signed)
conj_in  input  1  1: compute A*conj(B); 0: compute A*B
last_in  input  1  sideband, passed through aligned with data
valid_in  input  1  input sample valid
ready_out  output  1  block can accept input this cycle
i_out, q_out  output  OUT_WIDTH  scaled result (signed)
last_out  output  1  aligned last_in
valid_out  output  1  output valid
ready_in  input  1  downstream accepts output

Behaviour:
- One clock (clk_in). Reset is asynchronous and active-low (rst_n_in). Assertion clears all stage valids, valid_out, i_out, q_out and last_out to 0 immediately. Data registers may be left unreset.
- Transfer on input when valid_in && ready_out; transfer on output when valid_out && ready_in.
- Three-stage pipeline with global stall: stall = valid_out && !ready_in; ready_out = !stall. While stall, every stage holds (data, last, valid). Otherwise every stage advances, and stage 1 loads valid_in. Bubbles are not collapsed.
- Latency: exactly 3 cycles from input transfer to valid_out when ready_in is held high. Throughput is 1 sample per cycle.
- Stage 1: register operands, last and conj. If conj_in, B's Q is negated into a DATA_WIDTH+1 field, so -2^(DATA_WIDTH-1) negates exactly.
- Stage 2: register the four products i0*i1, q0*q1', i0*q1', q0*i1, where q1' is the conditionally negated Q. Products are full precision.
- Stage 3: I = i0*i1 − q0*q1' and Q = i0*q1' + q0*i1, computed at internal width W = 2*DATA_WIDTH+2 (no overflow possible).
- Rounding: round half up. Add 2^(SHIFT−1) when SHIFT > 0, then arithmetic right shift by SHIFT.
- Saturation: clamp to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1] independently for I and Q.
- The stage 3 result is registered into i_out/q_out/last_out/valid_out. Outputs are held stable while stall.
- valid_in with ready_out low: input is not taken. Upstream must hold it; the block places no requirement on input stability beyond AXI-stream rules.
- Simultaneous output transfer and input transfer in the same cycle is supported: the pipeline shifts and the new sample enters stage 1.
- Reset mid-stream: in-flight samples are discarded, with no partial outputs after release. ready_out is 1 in the first cycle after release.

Optional Feature:
COMPLEX_MULTIPLY_PIPE_SAT_FLAG_EN
- Defined: adds output port sat_out (1 bit), registered and aligned with valid_out. It is 1 when I or Q clamped for that sample and is held during stall. It resets to 0.
- Undefined: the port does not exist and no saturation-detect logic is generated.

Test Plan:
- Defaults, conj=0, A=(16384,16384), B=(16384,0), ready_in=1 -> valid_out exactly 3 cycles later, out=(8192,8192), last_out matches last_in.
- conj=1, A=(0,16384), B=(0,16384) -> out=(8192,0); same operands with conj=0 -> (−8192,0).
- Saturation: A=(−32768,0), B=(−32768,0) -> out=(32767,0); with flag macro, sat_out=1. B=(−32768,0), conj=1, A=(0,−32768) -> I=0, Q=32767, sat_out=1.
- Rounding: A=(1,0), B=(16384,0) -> I=1; B=(16383,0) -> I=0; A=(−1,0), B=(16384,0) -> I=0; A=(−1,0), B=(16385,0) -> I=−1.
- Backpressure: stream 20 random samples with last on #10, ready_in toggled pseudo-randomly -> output order, values and last match a golden model. No drop or duplicate; outputs stable while stalled; ready_out low only while valid_out && !ready_in.
- Reset mid-stream: assert rst_n_in low asynchronously with 3 samples in flight -> valid_out drops at once, no stale outputs after release, the next accepted sample appears 3 cycles later.
